// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch port (if_*) and the
//   load/store port (d_*). Each access runs IDLE -> BUSY -> DONE; contention
//   in IDLE alternates on the last-served requester (data wins first).
//   Byte enables and lane-replicated write data come from d_size/d_addr.
//   Load data is right-justified and sign-extended. A watchdog aborts a BUSY
//   access after TIMEOUT cycles without mem_ready.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   if_req/if_addr    fetch request (word access); if_rdata/if_ack/if_err
//   d_req/d_we/d_size/d_addr/d_wdata  data request; d_rdata/d_ack/d_err
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  memory strobe and payload
//   mem_rdata/mem_ready                        memory response
//
// Configuration
//   MEM_ARB_MISALIGN_EN  when defined, misaligned word/half data accesses and
//                        misaligned fetches complete with an error pulse and
//                        no memory access.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ack,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready
);

   localparam logic [1:0] SzWord = 2'b00;
   localparam logic [1:0] SzByte = 2'b01;
   localparam logic [1:0] SzRsvd = 2'b10;
   localparam logic [1:0] SzHalf = 2'b11;

   // Abort fires in the BUSY cycle whose count (including itself) hits TIMEOUT.
   localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e state_q, state_d;

   logic              last_d_q, last_d_d;   // 1 = data was granted last
   logic              sel_d_q, sel_d_d;     // 1 = current access is data
   logic              err_q, err_d;
   logic [7:0]        wd_q, wd_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       rdata_q, rdata_d;

   logic        any_req;
   logic        grant_d;
   logic        d_bad;
   logic        if_bad;
   logic        req_bad;
   logic        wd_hit;
   logic        done;
   logic [3:0]  d_be;
   logic [31:0] d_wd;
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_data;

   assign any_req = if_req | d_req;
   assign grant_d = d_req & (~if_req | ~last_d_q);
   assign wd_hit  = (wd_q == WdLast);

`ifdef MEM_ARB_MISALIGN_EN
   assign d_bad  = (d_size == SzRsvd)
                 | ((d_size == SzWord) & (d_addr[1:0] != 2'b00))
                 | ((d_size == SzHalf) & d_addr[0]);
   assign if_bad = (if_addr[1:0] != 2'b00);
`else
   logic unused_if_lsb;
   assign d_bad         = (d_size == SzRsvd);
   assign if_bad        = 1'b0;
   assign unused_if_lsb = ^if_addr[1:0];
`endif

   assign req_bad = grant_d ? d_bad : if_bad;

   // Store lane selection and replication.
   always_comb begin
      d_be = 4'b1111;
      d_wd = d_wdata;
      case (d_size)
         SzHalf: begin
            d_be = d_addr[1] ? 4'b1100 : 4'b0011;
            d_wd = {2{d_wdata[15:0]}};
         end
         SzByte: begin
            d_be = 4'b0001 << d_addr[1:0];
            d_wd = {4{d_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   // Load lane extraction from the registered size/offset of the access.
   always_comb begin
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (off_q)
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         2'd3:    ld_byte = mem_rdata[31:24];
         default: ld_byte = mem_rdata[7:0];
      endcase
      case (size_q)
         SzHalf:  ld_data = {{16{ld_half[15]}}, ld_half};
         SzByte:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         default: ld_data = mem_rdata;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (any_req) state_d = req_bad ? StDone : StBusy;
         StBusy: if (mem_ready || wd_hit) state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      done      = (state_q == StDone);
      mem_req   = (state_q == StBusy);
      mem_we    = mem_req & we_q;
      mem_be    = be_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if_ack    = done & ~sel_d_q & ~err_q;
      if_err    = done & ~sel_d_q & err_q;
      d_ack     = done & sel_d_q & ~err_q;
      d_err     = done & sel_d_q & err_q;
      if_rdata  = (done & ~sel_d_q) ? rdata_q : 32'h0;
      d_rdata   = (done & sel_d_q) ? rdata_q : 32'h0;
   end

   // Access payload, arbitration history and watchdog next state.
   always_comb begin
      last_d_d = last_d_q;
      sel_d_d  = sel_d_q;
      err_d    = err_q;
      wd_d     = wd_q;
      we_d     = we_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      off_d    = off_q;
      rdata_d  = rdata_q;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               last_d_d = grant_d;
               sel_d_d  = grant_d;
               err_d    = req_bad;
               wd_d     = 8'd0;
               if (grant_d) begin
                  we_d    = d_we;
                  be_d    = d_be;
                  addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                  wdata_d = d_wd;
                  size_d  = d_size;
                  off_d   = d_addr[1:0];
               end else begin
                  we_d    = 1'b0;
                  be_d    = 4'b1111;
                  addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
                  wdata_d = 32'h0;
                  size_d  = SzWord;
                  off_d   = 2'b00;
               end
            end
         end
         StBusy: begin
            // mem_ready beats the watchdog when both land in the same cycle.
            if (mem_ready) begin
               rdata_d = sel_d_q ? ld_data : mem_rdata;
               err_d   = 1'b0;
            end else if (wd_hit) begin
               err_d = 1'b1;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_d_q <= 1'b0;
         sel_d_q  <= 1'b0;
         err_q    <= 1'b0;
         wd_q     <= 8'd0;
         we_q     <= 1'b0;
         be_q     <= 4'b0000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         size_q   <= SzWord;
         off_q    <= 2'b00;
         rdata_q  <= 32'h0;
      end else begin
         last_d_q <= last_d_d;
         sel_d_q  <= sel_d_d;
         err_q    <= err_d;
         wd_q     <= wd_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         off_q    <= off_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed table of data accesses, hand-written
// arbitration/watchdog/reset sequences, and randomized traffic checked against
// a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [31:0]   if_rdata;
   logic          if_ack;
   logic          if_err;
   logic          d_req;
   logic          d_we;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata;
   logic          d_ack;
   logic          d_err;
   logic          mem_req;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ready;

   int checks = 0;
   int errors = 0;
   bit model_last_d;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W (AW),
      .TIMEOUT(TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ack   (if_ack),
      .if_err   (if_err),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_size   (d_size),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_ack    (d_ack),
      .d_err    (d_err),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_be   (mem_be),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rword;
      bit          ill;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword, input bit ill,
                          input logic [3:0] be, input logic [31:0] maddr,
                          input logic [31:0] mwdata, input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.rword = rword;
      v.ill = ill; v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.rdata = rdata;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   function automatic int unsigned m_bytes(input logic [1:0] size);
      return (size == 2'b00) ? 4 : (size == 2'b11) ? 2 : 1;
   endfunction

   function automatic int unsigned m_lane(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'b00) return 0;
      if (size == 2'b11) return ((addr % 4) / 2) * 2;
      return addr % 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      int unsigned n;
      n = m_bytes(size);
      return 4'(((1 << n) - 1) << m_lane(size, addr));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
      int unsigned n;
      n = m_bytes(size);
      if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
      if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
      return w;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [1:0] size, input logic [31:0] addr,
                                           input logic [31:0] w);
      int unsigned n;
      longint      v;
      n = m_bytes(size);
      v = longint'((64'(w) >> (8 * m_lane(size, addr))) & ((64'd1 << (8 * n)) - 64'd1));
      if (n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   function automatic bit m_d_bad(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ARB_MISALIGN_EN
      return (size == 2'b10) || (size == 2'b00 && addr % 4 != 0)
             || (size == 2'b11 && addr % 2 != 0);
`else
      return (size == 2'b10) && (addr == addr);
`endif
   endfunction

   function automatic bit m_if_bad(input logic [31:0] addr);
`ifdef MEM_ARB_MISALIGN_EN
      return (addr % 4) != 0;
`else
      return (addr != addr);
`endif
   endfunction

   // Runs one granted access starting in an IDLE cycle with requests driven.
   // Memory answers in BUSY cycle wait_cyc+1; beyond TO the watchdog aborts.
   task automatic serve(input bit is_data, input bit bad, input int wait_cyc,
                        input logic [31:0] rword, input logic exp_we, input logic [3:0] exp_be,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
      bit         ok;
      logic [3:0] exp_p;
      check("idle_mem_req", 32'(mem_req), 32'd0);
      check("idle_pulses", 32'({if_ack, if_err, d_ack, d_err}), 32'd0);
      mem_ready = 1'($urandom_range(0, 1));   // ignored outside BUSY
      mem_rdata = $urandom;
      tick();
      ok = 1'b0;
      if (!bad) begin
         ok = (wait_cyc + 1 <= int'(TO));
         for (int j = 1; j <= int'(TO); j++) begin
            check("busy_mem_req", 32'(mem_req), 32'd1);
            check("busy_mem_addr", mem_addr, exp_addr);
            check("busy_mem_be", 32'(mem_be), 32'(exp_be));
            check("busy_mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) check("busy_mem_wdata", mem_wdata, exp_wdata);
            mem_ready = (j == wait_cyc + 1);
            mem_rdata = (j == wait_cyc + 1) ? rword : $urandom;
            tick();
            if (j == wait_cyc + 1) break;
         end
      end
      exp_p = is_data ? (ok ? 4'b0010 : 4'b0001) : (ok ? 4'b1000 : 4'b0100);
      check("done_mem_req", 32'(mem_req), 32'd0);
      check("done_pulses", 32'({if_ack, if_err, d_ack, d_err}), 32'(exp_p));
      if (ok && !is_data) check("if_rdata", if_rdata, rword);
      if (ok && is_data && !exp_we) check("d_rdata", d_rdata, exp_rdata);
      mem_ready = 1'($urandom_range(0, 1));
      if (is_data) d_req = 1'b0;
      else if_req = 1'b0;
      tick();
      mem_ready = 1'b0;
   endtask

   task automatic serve_model(input bit is_data, input int wait_cyc, input logic [31:0] rword);
      if (is_data)
         serve(1'b1, m_d_bad(d_size, d_addr), wait_cyc, rword, d_we, m_be(d_size, d_addr),
               d_addr & ~32'h3, m_wdata(d_size, d_wdata), m_rdata(d_size, d_addr, rword));
      else
         serve(1'b0, m_if_bad(if_addr), wait_cyc, rword, 1'b0, 4'hF, if_addr & ~32'h3,
               32'h0, 32'h0);
      model_last_d = is_data;
   endtask

   task automatic transact(input bit want_if, input bit want_d, input int wait_if,
                           input int wait_d);
      bit first_d;
      if_req  = want_if;
      d_req   = want_d;
      first_d = (want_if && want_d) ? !model_last_d : want_d;
      serve_model(first_d, first_d ? wait_d : wait_if, $urandom);
      if (want_if && want_d) serve_model(!first_d, first_d ? wait_if : wait_d, $urandom);
   endtask

   task automatic set_d(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
      d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0;
      set_d(1'b0, 2'b00, 32'h0, 32'h0);
      mem_rdata = 32'h0; mem_ready = 1'b0;
      model_last_d = 1'b0;

      // Directed data-access table.
      add_vec(1, 2'b11, 32'h206, 32'h0000_BEEF, 32'h0, 0, 4'hC, 32'h204, 32'hBEEF_BEEF, 32'h0);
      add_vec(0, 2'b01, 32'h303, 32'h0, 32'h80FF_FF7F, 0, 4'h8, 32'h300, 32'h0, 32'hFFFF_FF80);
      add_vec(0, 2'b01, 32'h300, 32'h0, 32'h80FF_FF7F, 0, 4'h1, 32'h300, 32'h0, 32'h0000_007F);
      add_vec(0, 2'b01, 32'h301, 32'h0, 32'h80FF_FF7F, 0, 4'h2, 32'h300, 32'h0, 32'hFFFF_FFFF);
      add_vec(0, 2'b11, 32'h002, 32'h0, 32'h8001_1234, 0, 4'hC, 32'h000, 32'h0, 32'hFFFF_8001);
      add_vec(0, 2'b11, 32'h010, 32'h0, 32'h8001_1234, 0, 4'h3, 32'h010, 32'h0, 32'h0000_1234);
      add_vec(0, 2'b00, 32'h420, 32'h0, 32'hDEAD_BEEF, 0, 4'hF, 32'h420, 32'h0, 32'hDEAD_BEEF);
      add_vec(1, 2'b01, 32'h101, 32'h1234_56A5, 32'h0, 0, 4'h2, 32'h100, 32'hA5A5_A5A5, 32'h0);
      add_vec(1, 2'b00, 32'h0FC, 32'h1122_3344, 32'h0, 0, 4'hF, 32'h0FC, 32'h1122_3344, 32'h0);
      add_vec(0, 2'b10, 32'h600, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 32'h0);
      add_vec(1, 2'b11, 32'h040, 32'hFFFF_7ABC, 32'h0, 0, 4'h3, 32'h040, 32'h7ABC_7ABC, 32'h0);
`ifdef MEM_ARB_MISALIGN_EN
      add_vec(0, 2'b00, 32'h402, 32'h0, 32'h0102_0304, 1, 4'h0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 2'b11, 32'h203, 32'h0, 32'h8001_1234, 1, 4'h0, 32'h0, 32'h0, 32'h0);
`else
      add_vec(0, 2'b00, 32'h402, 32'h0, 32'h0102_0304, 0, 4'hF, 32'h400, 32'h0, 32'h0102_0304);
      add_vec(0, 2'b11, 32'h203, 32'h0, 32'h8001_1234, 0, 4'hC, 32'h200, 32'h0, 32'hFFFF_8001);
`endif

      // Reset state.
      tick(); tick(); tick();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_pulses", 32'({if_ack, if_err, d_ack, d_err}), 32'd0);
      check("rst_rdata", if_rdata | d_rdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // Fetch at 0x100, zero-wait memory.
      if_addr = 32'h100;
      transact(1'b1, 1'b0, 0, 0);

      // Contention: data first, then fetch; next pair goes to data again.
      if_addr = 32'h104; set_d(1'b0, 2'b00, 32'h800, 32'h0);
      transact(1'b1, 1'b1, 0, 1);
      if_addr = 32'h108; set_d(1'b1, 2'b00, 32'h804, 32'h5555_AAAA);
      transact(1'b1, 1'b1, 2, 0);

      // Table vectors.
      foreach (vecs[i]) begin
         set_d(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         if_req = 1'b0;
         d_req  = 1'b1;
         serve(1'b1, vecs[i].ill, i % 3, vecs[i].rword, vecs[i].we, vecs[i].be,
               vecs[i].maddr, vecs[i].mwdata, vecs[i].rdata);
         model_last_d = 1'b1;
      end

      // Watchdog: no ready for TO cycles aborts; ready in the TO-th cycle wins.
      set_d(1'b0, 2'b00, 32'h700, 32'h0);
      transact(1'b0, 1'b1, 0, int'(TO));
      transact(1'b0, 1'b1, 0, int'(TO) - 1);
      if_addr = 32'h10C;
      transact(1'b1, 1'b0, 10, 0);

      // Reset during BUSY abandons the access.
      set_d(1'b1, 2'b00, 32'h500, 32'hCAFE_F00D);
      d_req = 1'b1; mem_ready = 1'b0;
      tick();
      check("midrst_busy", 32'(mem_req), 32'd1);
      rst_n = 1'b0; d_req = 1'b0;
      tick();
      check("midrst_mem_req", 32'(mem_req), 32'd0);
      check("midrst_mem_we", 32'(mem_we), 32'd0);
      check("midrst_mem_be", 32'(mem_be), 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_mem_wdata", mem_wdata, 32'd0);
      check("midrst_pulses", 32'({if_ack, if_err, d_ack, d_err}), 32'd0);
      rst_n = 1'b1; mem_ready = 1'b1;
      tick();
      check("postrst_pulses", 32'({if_ack, if_err, d_ack, d_err}), 32'd0);
      check("postrst_mem_req", 32'(mem_req), 32'd0);
      mem_ready = 1'b0;
      model_last_d = 1'b0;
      // Arbitration history was cleared: data wins again.
      if_addr = 32'h110; set_d(1'b0, 2'b01, 32'h901, 32'h0);
      transact(1'b1, 1'b1, 0, 0);

      // Randomized traffic.
      for (int k = 0; k < 200; k++) begin
         int r;
         r = $urandom_range(1, 3);
         set_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               32'($urandom_range(0, 4095)), $urandom);
         if_addr = 32'($urandom_range(0, 4095)) & ~32'h3;
`ifdef MEM_ARB_MISALIGN_EN
         if ($urandom_range(0, 3) == 0) if_addr = if_addr | 32'($urandom_range(1, 3));
`endif
         transact(r[0], r[1], $urandom_range(0, 5), $urandom_range(0, 5));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single-port unified memory between the instruction-fetch stage and the load/store path of the MIPS datapath. It takes the access size encoding produced by the main decoder, generates byte enables and aligned write data, and returns right-justified load data. A per-access watchdog bounds memory stalls. Both requesters use a req/ack handshake.

## Interface
- ADDR_W, 32, byte address width
- TIMEOUT, 255, max cycles `mem_req` may wait for `mem_ready` before abort (1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request, held until `if_ack`/`if_err`
- if_addr  in  ADDR_W  fetch address (word access)
- if_rdata  out  32  fetched word, valid with `if_ack`
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  one-cycle pulse: watchdog abort or misaligned fetch
- d_req  in  1  data request, held until `d_ack`/`d_err`
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 word, 11 half, 01 byte, 10 reserved
- d_addr  in  ADDR_W  byte address
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  load data, right-justified, sign-extended for half/byte
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  one-cycle pulse: illegal size, misalign, or watchdog abort
- mem_req  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_be  out  4  byte enables (bit i = byte lane i, little-endian)
- mem_addr  out  ADDR_W  word-aligned address (`[1:0]` = 0)
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read data, valid when `mem_ready`
- mem_ready  in  1  access completes this cycle

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: sample requests. When only one request is present, grant it. When both are present, grant the requester not served last (`last_d` bit). Reset value of `last_d` is 0, so the first contention goes to data. Register `mem_*`, set `last_d`, go to BUSY.
- Illegal data request in IDLE (`d_size`=10): no memory access, go to DONE with `d_err`. `last_d` still updates.
- BUSY: `mem_req`=1, all `mem_*` stable. On `mem_ready`, capture `mem_rdata` and go to DONE with ack. If the watchdog counter reaches TIMEOUT without `mem_ready`: drop `mem_req` and go to DONE with err.
- DONE: exactly one of `if_ack`/`if_err`/`d_ack`/`d_err` is 1. Requests are ignored. Next state is IDLE.
- Byte enables: word 1111. Half: `addr[1]`=0 → 0011, 1 → 1100. Byte: one-hot on `addr[1:0]`.
- Write data: half is replicated to both halves; byte is replicated to all four lanes.
- Load data: the selected lane is shifted down and sign-extended from bit 15 (half) or bit 7 (byte). Word is passed through.
- Fetch is always a word access with `mem_we`=0.

## Timing
- Reset (`rst_n` low at an edge): state IDLE, `last_d`=0, watchdog=0, all outputs 0. Reset always wins, including mid-BUSY; the in-flight access is abandoned and no ack is issued.
- Zero-wait memory: request seen in cycle 0 (IDLE), `mem_req` in cycle 1, ack in cycle 2, IDLE in cycle 3.
- Each wait cycle of `mem_ready` adds one cycle. Minimum is 3 cycles per access.
- Requesters hold address, data and size from `req` rise until the ack/err cycle. They may drop `req` or present a new access at the edge ending that cycle.
- Watchdog: cleared on entry to BUSY, increments each BUSY cycle without `mem_ready`. Abort happens in the cycle the count equals TIMEOUT. `mem_ready` in that same cycle wins, giving ack, not err.
- `mem_ready` outside BUSY is ignored.
- Requests arriving simultaneously in the same IDLE cycle are resolved by `last_d`. A request arriving during BUSY or DONE waits for IDLE.

## Configuration
- `MEM_ARB_MISALIGN_EN` defined:
  - A data access with word and `addr[1:0]`≠0, or half and `addr[0]`=1, gets no memory access and a `d_err` pulse via DONE (2-cycle latency).
  - A fetch with `if_addr[1:0]`≠0 gets an `if_err` pulse the same way.
- Undefined: no alignment checks. Address low bits are dropped on `mem_addr` and lanes are chosen from `addr[1:0]` as above, so a misaligned half at offset 3 selects lanes 3:2.

## Test plan
- Reset, then `if_req` at `if_addr`=0x100, memory ready immediately → `mem_addr`=0x100, `mem_be`=1111 in cycle 1; `if_ack` with `if_rdata`=`mem_rdata` in cycle 2.
- `d_req` and `if_req` both rise after reset → data granted first, fetch next; a third simultaneous pair → data again (alternation).
- Store half 0xBEEF at 0x206 → `mem_addr`=0x204, `mem_be`=1100, `mem_wdata`=0xBEEFBEEF, `mem_we`=1.
- Load byte at 0x303, `mem_rdata`=0x80FF_FF7F → `d_rdata`=0xFFFF_FF80.
- `mem_ready` held low, TIMEOUT=4 → `mem_req` high 4 cycles, then `d_err` pulse. Repeat with `mem_ready` in the 4th cycle → `d_ack`, no err.
- `d_size`=10 → `d_err`, no `mem_req`. With `MEM_ARB_MISALIGN_EN`, load word at 0x402 → `d_err`. Assert `rst_n`=0 mid-BUSY → all outputs 0 next cycle, no ack.
